bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared system bus that drives rom, ram and uart.
- Master 0 is the core's load/store path; master 1 is a secondary requester, such as a boot loader or DMA.
- Grants one transaction at a time, decodes the address into the one-hot chip-select vector, and drives the bus for a single access cycle.
- Captures read data and returns an ack, with an error flag for unmapped addresses.

Parameters:
- ROM_REGION, 4'h0: value of addr[31:28] that selects ROM.
- RAM_REGION, 4'h1: value of addr[31:28] that selects RAM.
- UART_REGION, 4'h2: value of addr[31:28] that selects UART.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  master 0 request; held high until m0_ack_o.
- m0_we_i  in  1  master 0 write (1) / read (0).
- m0_addr_i  in  32  master 0 address.
- m0_wdata_i  in  32  master 0 write data.
- m0_hb_i  in  2  master 0 half-word/byte size code, passed through to bus_hb_o.
- m0_ack_o  out  1  one-cycle transaction-complete pulse.
- m0_err_o  out  1  valid with m0_ack_o; 1 means the address was unmapped.
- m0_rdata_o  out  32  read data; valid with m0_ack_o.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_hb_i, m1_ack_o, m1_err_o, m1_rdata_o: same as master 0, for master 1.
- bus_addr_o  out  32  shared bus address.
- bus_data_o  out  32  shared bus write data.
- bus_we_o  out  1  bus write strobe.
- bus_hb_o  out  2  bus size code.
- bus_cs_o  out  3  one-hot select {uart, ram, rom}.
- rom_data_i  in  32  ROM read data (combinational).
- ram_data_i  in  32  RAM read data (combinational).
- uart_data_i  in  32  UART read data (combinational).
- owner_o  out  1  index of the master currently or last granted.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; the round-robin pointer favours m0; owner_o=0.
  - All ack/err/rdata outputs are 0.
  - bus_we_o=0, bus_cs_o=0, bus_addr_o/bus_data_o/bus_hb_o=0.
  - An in-flight transaction is dropped with no ack. After release, requesters must re-request; held requests are re-arbitrated normally.
- FSM states:
  - IDLE: if any req is high, pick a winner, latch its we/addr/wdata/hb into internal registers, set owner_o, go to ACCESS. Otherwise stay.
  - ACCESS (exactly 1 cycle):
    - Drive the latched addr/wdata/hb on the bus.
    - bus_cs_o is the decode of latched addr[31:28]: 3'b001 ROM, 3'b010 RAM, 3'b100 UART, 3'b000 unmapped.
    - bus_we_o = latched we AND mapped.
    - On the clock edge, capture the read mux (selected slave data, or 0 if unmapped/write) into the rdata register. Go to RESP.
  - RESP (1 cycle):
    - Pulse the winner's ack_o=1 and err_o=(unmapped), with rdata_o valid.
    - bus_cs_o=0, bus_we_o=0; bus_addr_o holds its last value.
    - Advance the pointer so the other master has priority. Go to IDLE.
- Latency: req sampled in IDLE at edge N → ACCESS during cycle N+1 → ack during cycle N+2. Maximum throughput is 1 transaction per 3 cycles.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting: the master indicated by the pointer wins.
  - The pointer flips after each completed transaction, giving strict alternation under continuous contention.
- Handshake:
  - Request fields are sampled only on the grant edge. Later changes to req, addr or data do not affect the granted transaction.
  - A master dropping req mid-transaction still receives its ack.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
- Non-owner outputs: ack/err are 0. rdata_o for each master is registered and holds its last value.
- ROM writes are not blocked: bus_we_o is asserted with ROM cs, and ROM ignores it. Err is raised only for unmapped addresses.

Test Plan:
- m0 writes 0xDEADBEEF to 0x1000_0010 (hb=2'b10), then reads it back. Required: ACCESS cycle shows bus_cs_o=3'b010 and bus_we_o=1; ack 2 cycles after req; rdata=0xDEADBEEF; err=0.
- m0 and m1 both hold reads (0x0000_0004 and 0x2000_0000) for 4 transactions. Required: grants m0, m1, m0, m1; owner_o alternates; each ack is 3 cycles apart.
- m1 reads 0x3000_0000. Required: bus_cs_o=0, bus_we_o=0; m1_ack_o=1 with m1_err_o=1 and m1_rdata_o=0.
- m0 issues a UART write of 0x41, deasserting req and changing addr during ACCESS. Required: bus_cs_o=3'b100 with data 0x41 for exactly 1 cycle; m0_ack_o still pulses.
- Assert rst_i during ACCESS of an m1 write. Required: bus_we_o and bus_cs_o go to 0 immediately (async); no ack. After release, a held m0 req is granted first.
- Idle bus with no requests for 10 cycles. Required: bus_cs_o=0 and bus_we_o=0 throughout; no acks.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter sequencing single-cycle rom/ram/uart accesses
module bus_arbiter #(
    parameter logic [3:0] ROM_REGION  = 4'h0,
    parameter logic [3:0] RAM_REGION  = 4'h1,
    parameter logic [3:0] UART_REGION = 4'h2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [1:0]  m0_hb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [1:0]  m1_hb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic        bus_we_o,
    output logic [1:0]  bus_hb_o,
    output logic [2:0]  bus_cs_o,
    input  logic [31:0] rom_data_i,
    input  logic [31:0] ram_data_i,
    input  logic [31:0] uart_data_i,
    output logic        owner_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic ptr, win, win_we, lat_we;
    logic [31:0] win_addr, rd_mux;
    logic [2:0] win_cs;

    // pick the winner, decode its address region and mux the selected slave's read data
    always_comb begin
        win      = (m0_req_i && m1_req_i) ? ptr : m1_req_i;
        win_we   = win ? m1_we_i : m0_we_i;
        win_addr = win ? m1_addr_i : m0_addr_i;
        win_cs   = (win_addr[31:28] == ROM_REGION)  ? 3'b001 :
                   (win_addr[31:28] == RAM_REGION)  ? 3'b010 :
                   (win_addr[31:28] == UART_REGION) ? 3'b100 : 3'b000;
        rd_mux   = lat_we      ? '0 :
                   bus_cs_o[0] ? rom_data_i :
                   bus_cs_o[1] ? ram_data_i :
                   bus_cs_o[2] ? uart_data_i : '0;
    end

    // grant in IDLE, drive the bus for one ACCESS cycle, pulse the owner's ack in RESP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner_o    <= 1'b0;
            lat_we     <= 1'b0;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            bus_hb_o   <= '0;
            bus_cs_o   <= '0;
            bus_we_o   <= 1'b0;
            m0_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_ack_o   <= 1'b0;
            m1_err_o   <= 1'b0;
            m1_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (m0_req_i || m1_req_i) begin
                    state      <= ACCESS;
                    owner_o    <= win;
                    lat_we     <= win_we;
                    bus_addr_o <= win_addr;
                    bus_data_o <= win ? m1_wdata_i : m0_wdata_i;
                    bus_hb_o   <= win ? m1_hb_i : m0_hb_i;
                    bus_cs_o   <= win_cs;
                    bus_we_o   <= win_we && |win_cs;
                end
                ACCESS: begin
                    state    <= RESP;
                    bus_cs_o <= '0;
                    bus_we_o <= 1'b0;
                    if (owner_o) begin
                        m1_rdata_o <= rd_mux;
                        m1_ack_o   <= 1'b1;
                        m1_err_o   <= ~|bus_cs_o;
                    end else begin
                        m0_rdata_o <= rd_mux;
                        m0_ack_o   <= 1'b1;
                        m0_err_o   <= ~|bus_cs_o;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ptr      <= ~owner_o;
                    m0_ack_o <= 1'b0;
                    m0_err_o <= 1'b0;
                    m1_ack_o <= 1'b0;
                    m1_err_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random transactions checked against a transaction-level model
module tb_bus_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [1:0]  m0_hb_i, m1_hb_i, bus_hb_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, bus_we_o, owner_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, bus_addr_o, bus_data_o;
    logic [31:0] rom_data_i, ram_data_i, uart_data_i;
    logic [2:0]  bus_cs_o;
    logic [31:0] ram_mem [256] = '{default: 32'h0};

    int vectors = 0, miscompares = 0;
    int e = 0, g_edge = -10;
    logic g_m, t_we, ptr_m, own, acc_now, rsp_now;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_hb;
    logic [31:0] rd_exp [2];
    logic [31:0] mram [256] = '{default: 32'h0};

    bus_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_hb_i(m0_hb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_hb_i(m1_hb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o),
        .bus_hb_o(bus_hb_o), .bus_cs_o(bus_cs_o),
        .rom_data_i(rom_data_i), .ram_data_i(ram_data_i), .uart_data_i(uart_data_i),
        .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    // slave responders: rom and uart derive data from the address, ram is a small memory
    assign rom_data_i  = ~bus_addr_o;
    assign uart_data_i = bus_addr_o ^ 32'h5500;
    assign ram_data_i  = ram_mem[bus_addr_o[9:2]];
    always @(posedge clk_i) if (bus_we_o && bus_cs_o[1]) ram_mem[bus_addr_o[9:2]] <= bus_data_o;

    function automatic logic [2:0] dec(input logic [31:0] a);
        return (a[31:28] == 4'h0) ? 3'b001 : (a[31:28] == 4'h1) ? 3'b010 :
               (a[31:28] == 4'h2) ? 3'b100 : 3'b000;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [2:0] c;
        c = dec(t_addr);
        if (t_we) return 32'h0;
        return c[0] ? ~t_addr : c[1] ? mram[t_addr[9:2]] : c[2] ? (t_addr ^ 32'h5500) : 32'h0;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [3:0] r;
        r = 4'($urandom_range(0, 4));
        if (r == 4'h4) r = 4'hF;
        return {r, 18'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, e, got, exp);
        end
    endtask

    task automatic model_reset();
        g_edge = -10; ptr_m = 1'b0; own = 1'b0; g_m = 1'b0;
        t_we = 1'b0; t_addr = '0; t_wdata = '0; t_hb = '0;
        rd_exp[0] = '0; rd_exp[1] = '0;
    endtask

    task automatic set_m(input int i, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] hb);
        if (i == 0) begin
            m0_req_i = r; m0_we_i = we; m0_addr_i = a; m0_wdata_i = d; m0_hb_i = hb;
        end else begin
            m1_req_i = r; m1_we_i = we; m1_addr_i = a; m1_wdata_i = d; m1_hb_i = hb;
        end
    endtask

    task automatic rnd_m(input int i, input logic r);
        set_m(i, r, 1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 2'($urandom_range(0, 3)));
    endtask

    // one clock: advance the model at the edge, then compare every output
    task automatic step();
        logic [2:0] cs_e;
        @(posedge clk_i);
        e++;
        if (rst_i) model_reset();
        else begin
            if (e == g_edge + 1) begin
                rd_exp[g_m] = exp_read();
                if (t_we && dec(t_addr) == 3'b010) mram[t_addr[9:2]] = t_wdata;
            end
            if (e == g_edge + 2) ptr_m = ~g_m;
            if (e >= g_edge + 3 && (m0_req_i || m1_req_i)) begin
                g_m = (m0_req_i && m1_req_i) ? ptr_m : m1_req_i;
                own = g_m; g_edge = e;
                t_we    = g_m ? m1_we_i : m0_we_i;
                t_addr  = g_m ? m1_addr_i : m0_addr_i;
                t_wdata = g_m ? m1_wdata_i : m0_wdata_i;
                t_hb    = g_m ? m1_hb_i : m0_hb_i;
            end
        end
        #1;
        acc_now = (e == g_edge);
        rsp_now = (e == g_edge + 1);
        cs_e = acc_now ? dec(t_addr) : 3'b000;
        check("cs", 32'(bus_cs_o), 32'(cs_e));
        check("we", 32'(bus_we_o), 32'(acc_now && t_we && cs_e != 3'b000));
        check("ack0", 32'(m0_ack_o), 32'(rsp_now && !g_m));
        check("ack1", 32'(m1_ack_o), 32'(rsp_now && g_m));
        check("err0", 32'(m0_err_o), 32'(rsp_now && !g_m && dec(t_addr) == 3'b000));
        check("err1", 32'(m1_err_o), 32'(rsp_now && g_m && dec(t_addr) == 3'b000));
        check("rdata0", m0_rdata_o, rd_exp[0]);
        check("rdata1", m1_rdata_o, rd_exp[1]);
        check("owner", 32'(owner_o), 32'(own));
        check("addr", bus_addr_o, t_addr);
        check("wdata", bus_data_o, t_wdata);
        check("hb", 32'(bus_hb_o), 32'(t_hb));
    endtask

    // run n cycles, dropping each master's request in its ack cycle
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (rsp_now) set_m(int'(g_m), 1'b0, 1'b0, '0, '0, 2'b00);
        end
    endtask

    task automatic txn(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] hb);
        set_m(i, 1'b1, we, a, d, hb);
        step();
        step();
        check("ack_latency", 32'(i == 0 ? m0_ack_o : m1_ack_o), 32'h1);
        set_m(i, 1'b0, 1'b0, '0, '0, 2'b00);
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        set_m(0, 1'b0, 1'b0, '0, '0, 2'b00);
        set_m(1, 1'b0, 1'b0, '0, '0, 2'b00);
        model_reset();
        step();
        step();
        rst_i = 1'b0;
        step();
        set_m(0, 1'b1, 1'b0, 32'h0000_0004, '0, 2'b00);
        set_m(1, 1'b1, 1'b0, 32'h2000_0000, '0, 2'b00);
        for (int k = 0; k < 12; k++) begin
            step();
            if (acc_now) check("alternate", 32'(owner_o), 32'((k / 3) % 2));
        end
        set_m(0, 1'b0, 1'b0, '0, '0, 2'b00);
        set_m(1, 1'b0, 1'b0, '0, '0, 2'b00);
        step();
        txn(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'b10);
        txn(0, 1'b0, 32'h1000_0010, 32'h0, 2'b10);
        check("readback", m0_rdata_o, 32'hDEAD_BEEF);
        txn(1, 1'b0, 32'h3000_0000, 32'h0, 2'b00);
        check("unmapped_rdata", m1_rdata_o, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h2000_0000, 32'h41, 2'b00);
        step();
        check("uart_cs", 32'(bus_cs_o), 32'h4);
        check("uart_data", bus_data_o, 32'h41);
        set_m(0, 1'b0, 1'b1, 32'h1000_0000, 32'h99, 2'b00);
        step();
        check("uart_ack", 32'(m0_ack_o), 32'h1);
        step();
        set_m(1, 1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678, 2'b00);
        step();
        set_m(0, 1'b1, 1'b0, 32'h0000_0008, '0, 2'b00);
        rst_i = 1'b1;
        model_reset();
        #1;
        check("rst_async_cs", 32'(bus_cs_o), 32'h0);
        check("rst_async_we", 32'(bus_we_o), 32'h0);
        step();
        rst_i = 1'b0;
        step();
        check("rst_first_owner", 32'(owner_o), 32'h0);
        drain(8);
        drain(10);
        for (int k = 0; k < 400; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (rsp_now && int'(g_m) == i) rnd_m(i, 1'($urandom_range(0, 1)));
                else if (!(i == 0 ? m0_req_i : m1_req_i)) begin
                    if ($urandom_range(0, 9) < 4) rnd_m(i, 1'b1);
                end else if (acc_now && int'(g_m) == i) rnd_m(i, $urandom_range(0, 9) >= 3);
            end
        end
        set_m(0, 1'b0, 1'b0, '0, '0, 2'b00);
        set_m(1, 1'b0, 1'b0, '0, '0, 2'b00);
        drain(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
